// File: rtl/sys_sequencer.sv
// sys_sequencer: top-level run controller for the 16-bit cpu core.
// Meters cpu steps with a clock enable, runs the power-on clear sequence and
// services sys instructions (halt, output word, input word) over valid/ready.
module sys_sequencer #(
    parameter int CLEAR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [15:0] cpu_pc,
    input  logic        cpu_sys,
    input  logic [47:0] cpu_sysregs,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] cpu_ins,
    output logic        cpu_clk_en,
    output logic        cpu_clear,
    output logic        cpu_load,
    output logic [15:0] cpu_load_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        halted,
    output logic        busy,
    output logic [15:0] instr_count
);

    localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        OUT_WAIT,
        IN_WAIT,
        STEP,
        HALT
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] clear_cnt;
    logic             step_load;
    logic [15:0]      sys_code;
    logic [15:0]      sys_arg;
    logic             sysregs_unused;

    // The instruction path is a pure pass-through between cpu and ROM.
    assign imem_addr = cpu_pc;
    assign cpu_ins   = imem_data;

    // Syscall code lives in r1, operand in r2; r3 is not needed here.
    assign sys_code       = cpu_sysregs[15:0];
    assign sys_arg        = cpu_sysregs[31:16];
    assign sysregs_unused = ^cpu_sysregs[47:32];

    // Flags decoded straight from the state register.
    assign cpu_load = (state == STEP) && step_load;
    assign halted   = (state == HALT);
    assign busy     = (state != IDLE) && (state != HALT);

    // State register; clear returns to IDLE from anywhere, abandoning handshakes.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode; the RUN clock enable is gated by cpu_sys
    // combinationally so the cpu never steps past a sys word.
    always_comb begin
        next_state = state;
        cpu_clk_en = 1'b0;
        cpu_clear  = 1'b0;
        out_valid  = 1'b0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RESET;
                end
            end
            RESET: begin
                cpu_clear  = 1'b1;
                cpu_clk_en = 1'b1;
                if (clear_cnt == CNT_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                cpu_clk_en = !cpu_sys;
                if (cpu_sys) begin
                    case (sys_code)
                        16'd0:   next_state = HALT;
                        16'd1:   next_state = OUT_WAIT;
                        16'd2:   next_state = IN_WAIT;
                        default: next_state = STEP;
                    endcase
                end
            end
            OUT_WAIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = STEP;
                end
            end
            IN_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = STEP;
                end
            end
            STEP: begin
                cpu_clk_en = 1'b1;
                next_state = RUN;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: clear-sequence counter, syscall operand/input latches, the
    // load-on-step flag and the saturating retired-step counter. A clear issued
    // from an active state keeps instr_count so the aborted run can be inspected;
    // the next start zeros it.
    always_ff @(posedge clk) begin
        if (clear) begin
            clear_cnt     <= '0;
            out_data      <= '0;
            cpu_load_data <= '0;
            step_load     <= 1'b0;
            case (state)
                RESET, RUN, OUT_WAIT, IN_WAIT, STEP, HALT: ;
                default: instr_count <= '0;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        clear_cnt   <= '0;
                        instr_count <= '0;
                    end
                end
                RESET: begin
                    clear_cnt <= clear_cnt + 1'b1;
                end
                RUN: begin
                    if (cpu_sys) begin
                        out_data  <= sys_arg;
                        step_load <= 1'b0;
                    end else if (instr_count != 16'hFFFF) begin
                        instr_count <= instr_count + 16'd1;
                    end
                end
                IN_WAIT: begin
                    if (in_valid) begin
                        cpu_load_data <= in_data;
                        step_load     <= 1'b1;
                    end
                end
                STEP: begin
                    step_load <= 1'b0;
                    if (instr_count != 16'hFFFF) begin
                        instr_count <= instr_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sys_sequencer.md
# sys_sequencer

Top-level run controller for the 16-bit `cpu` core. It fetches instructions from a combinational instruction memory and meters CPU steps with a clock enable. It also runs the power-on clear sequence and services `sys` instructions (halt, output word, input word) through valid/ready ports. It sits between the `cpu` instance, instruction ROM, and the board-level I/O.

## Interface
- `CLEAR_CYCLES`, default 2: number of cycles `cpu_clear` is held during the reset sequence (≥1).
- `clk`  in  1: system clock.
- `clear`  in  1: synchronous, active-high reset.
- `start`  in  1: begin the reset sequence and run. Sampled only in IDLE.
- `cpu_pc`  in  16: CPU program counter.
- `cpu_sys`  in  1: CPU `sys_signal`.
- `cpu_sysregs`  in  48: CPU `{r3, r2, r1}`.
- `imem_addr`  out  16: instruction address. Always equals `cpu_pc`.
- `imem_data`  in  16: instruction word (combinational read).
- `cpu_ins`  out  16: instruction to CPU. Always equals `imem_data`.
- `cpu_clk_en`  out  1: CPU advances on a `clk` edge only when high. An external gate cell drives the CPU clock.
- `cpu_clear`  out  1: drives CPU `clear`.
- `cpu_load`  out  1: drives CPU `load_signal`.
- `cpu_load_data`  out  16: drives CPU `load_data`.
- `out_valid`  out  1 / `out_ready`  in  1 / `out_data`  out  16: output-word handshake.
- `in_valid`  in  1 / `in_ready`  out  1 / `in_data`  in  16: input-word handshake.
- `halted`  out  1: high in HALT.
- `busy`  out  1: high in any state except IDLE and HALT.
- `instr_count`  out  16: number of retired CPU steps since the last reset sequence. Saturates at 16'hFFFF.

## Operation
- States: IDLE, RESET, RUN, OUT_WAIT, IN_WAIT, STEP, HALT.
- Syscall code is `r1` = `cpu_sysregs[15:0]`. Operand is `r2` = `cpu_sysregs[31:16]`.
- **IDLE:** `cpu_clk_en`=0. `start`=1 → RESET, clearing the cycle counter.
- **RESET:**
  - `cpu_clear`=1 and `cpu_clk_en`=1 for exactly `CLEAR_CYCLES` cycles, then → RUN.
  - `instr_count` is zeroed on entry.
- **RUN:**
  - When `cpu_sys`=0: `cpu_clk_en`=1 and `instr_count`+1 each cycle.
  - When `cpu_sys`=1: `cpu_clk_en`=0, so the PC freezes on the `sys` word. `r2` is latched into `out_data`, then dispatch:
    - code 0 → HALT.
    - code 1 → OUT_WAIT.
    - code 2 → IN_WAIT.
    - any other code → STEP (no-op syscall).
- **OUT_WAIT:** `out_valid`=1 and `out_data` is held stable. On `out_valid`&`out_ready` → STEP.
- **IN_WAIT:** `in_ready`=1. On `in_valid`&`in_ready`, `in_data` is latched into `cpu_load_data` → STEP.
- **STEP:**
  - One cycle with `cpu_clk_en`=1. The CPU executes the `sys` word (its dest write is nulled) and the PC advances.
  - `cpu_load`=1 only if STEP was entered from IN_WAIT, so CPU reg 3 takes `cpu_load_data` on this edge.
  - `instr_count`+1, then → RUN.
- **HALT:** `cpu_clk_en`=0 and `halted`=1. Exits only on `clear`. `start` is ignored.
- `start` in any state other than IDLE is ignored.
- `clear` in any state, mid-handshake included, → IDLE on the next edge. `out_valid` and `in_ready` drop; no transfer is completed or lost silently (the handshake is abandoned).

## Timing
- Reset values: state IDLE; `cpu_clk_en`=0, `cpu_clear`=0, `cpu_load`=0, `cpu_load_data`=0, `out_valid`=0, `out_data`=0, `in_ready`=0, `halted`=0, `busy`=0, `instr_count`=0.
- `cpu_clk_en`, `cpu_clear`, `cpu_load`, `out_valid`, `in_ready`, `halted` and `busy` are decoded from state. The only exception is the RUN-state `cpu_sys` gating of `cpu_clk_en`, which is combinational, so no extra step is executed past a `sys` word.
- `start` to first RUN step: 1 + `CLEAR_CYCLES` cycles.
- `sys` detection to dispatch: 1 cycle.
- Output syscall minimum: RUN(sys) → OUT_WAIT → STEP, i.e. 3 cycles with `out_ready` tied high.
- Input syscall minimum: RUN(sys) → IN_WAIT → STEP, i.e. 3 cycles with `in_valid` tied high.
- `out_data` and `cpu_load_data` stay stable from latch until the next latch or `clear`.
- `instr_count` saturates; it does not wrap at 16'hFFFF.

## Test plan
- `clear`, then `start` with `CLEAR_CYCLES`=2 → `cpu_clear` is high exactly 2 cycles, then RUN, `pc` counts 0,1,2…, and `instr_count` tracks the number of steps.
- Program with a `sys` word at address 3, r1=1, r2=16'h00A5, and `out_ready` low for 4 cycles → PC holds 3, `out_valid`=1 with `out_data`=16'h00A5 for 4 cycles, then one STEP, and PC=4.
- `sys` word with r1=2 and `in_data`=16'h1234 after 3 stalled cycles → STEP has `cpu_load`=1, CPU r3=16'h1234 afterwards, and PC advances by 1.
- `sys` word with r1=0 → `halted`=1, `cpu_clk_en`=0, PC frozen for 20 cycles, and `start` ignored. `clear` → IDLE with `halted`=0.
- `clear` asserted during OUT_WAIT → next cycle `out_valid`=0, state IDLE, and `instr_count` preserved until the next `start` zeros it. Also cover `sys` with r1=7 → single STEP, no handshake.
